// File: rtl/riscv_pkg.sv
// Shared RISC-V core types and constants.
// Holds the fetch-stage FSM encoding, the fetch buffer entry and the reset PC.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;
  localparam int FETCH_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_ctrl_fifo.sv
// Instruction buffer between the memory response and decode.
// Flush has priority over push and pop; the head is read straight from the entry flops.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  fetch_entry_t               push_data_i,
  input  logic                       pop_i,
  output logic                       head_valid_o,
  output fetch_entry_t               head_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    r_mem [DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic            w_pop;

  assign w_pop = pop_i && (r_count != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_i) begin
        r_mem[r_wr_ptr] <= push_data_i;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({push_i, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_valid_o = (r_count != '0);
  assign head_o       = r_mem[r_rd_ptr];
  assign count_o      = r_count;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, keeps one memory request in
// flight, buffers responses for decode and kills in-flight work on redirect.
//
//   state | meaning
//   IDLE  | one cycle after reset before the first request
//   REQ   | request fetch_pc while the buffer has room
//   WAIT  | granted, waiting for the response to push
//   DROP  | response belongs to a redirected-away path, discard it
module fetch_ctrl
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = riscv_pkg::RESET_PC,
  parameter int              FIFO_DEPTH = riscv_pkg::FETCH_FIFO_DEPTH
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [31:0]     mem_rdata_i,
  output logic            instr_valid_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_issued_pc;
  logic [CW-1:0]   w_count;
  logic            w_gnt;
  logic            w_push;
  logic            w_pop;
  logic            w_unused_pc_lo;
  fetch_entry_t    w_push_data;
  fetch_entry_t    w_head;

  // Low target bits are forced to zero, so they are deliberately unread.
  assign w_unused_pc_lo = ^redirect_pc_i[1:0];

  assign mem_req_o  = (r_state == REQ) && (w_count < CW'(FIFO_DEPTH));
  assign mem_addr_o = r_fetch_pc;
  assign w_gnt      = mem_req_o && mem_gnt_i;

  assign w_push = (r_state == WAIT) && mem_rvalid_i && !redirect_i;
  assign w_pop  = instr_valid_o && instr_ready_i && !redirect_i;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: w_state_nxt = REQ;
      REQ: begin
        if (w_gnt) w_state_nxt = redirect_i ? DROP : WAIT;
      end
      WAIT: begin
        if (mem_rvalid_i)    w_state_nxt = REQ;
        else if (redirect_i) w_state_nxt = DROP;
      end
      DROP: begin
        if (mem_rvalid_i) w_state_nxt = REQ;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_fetch_pc  <= RESET_PC;
      r_issued_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (redirect_i) begin
        r_fetch_pc <= {redirect_pc_i[XLEN-1:2], 2'b00};
      end else if (w_gnt) begin
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
      end
      if (w_gnt) begin
        r_issued_pc <= r_fetch_pc;
      end
    end
  end

  assign w_push_data.pc    = r_issued_pc;
  assign w_push_data.instr = mem_rdata_i;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (redirect_i),
    .push_i       (w_push),
    .push_data_i  (w_push_data),
    .pop_i        (w_pop),
    .head_valid_o (instr_valid_o),
    .head_o       (w_head),
    .count_o      (w_count)
  );

  assign instr_o    = w_head.instr;
  assign instr_pc_o = w_head.pc;

endmodule
